// File: rtl/vector_seq_pkg.sv
// Shared types and sizing helpers for the vector sequencer and its compare delay line.
// No logic; the compare-pipe entry is declared in the top because its field widths follow that module's parameters.
package vector_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } seq_state_e;

    // Width needed to hold a count 0..depth inclusive.
    function automatic int calc_iw(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vector_seq_delay.sv
// LATENCY-stage shift register for compare-pipe entries, cleared synchronously by rst.
// Latency LATENCY cycles (wire-through at 0); no backpressure, shifts every cycle.
module vector_seq_delay #(
    parameter int W       = 1,
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (LATENCY == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk | rst;
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] sr [LATENCY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < LATENCY; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= d;
                    for (int k = 1; k < LATENCY; k++) sr[k] <= sr[k-1];
                end
            end

            assign q = sr[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/vector_sequencer.sv
// Replays a loaded (a, b, exp) table onto a DUT, one vector per cycle, and checks x after LATENCY cycles.
// start-to-done latency num+LATENCY+1 cycles; no backpressure, loads and start are ignored while a run is active.
module vector_sequencer #(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 16,
    parameter  int LATENCY = 1,
    localparam int IW      = vector_seq_pkg::calc_iw(DEPTH),
    localparam int AW      = vector_seq_pkg::addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    input  logic [WIDTH-1:0] load_exp,
    input  logic [IW-1:0]    num_vec,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IW-1:0]    err_count,
    output logic [IW-1:0]    first_err,
    output logic [31:0]      cyc
);

    import vector_seq_pkg::*;

    typedef struct packed {
        logic             valid;
        logic [IW-1:0]    idx;
        logic [WIDTH-1:0] exp;
    } pipe_t;

    logic [WIDTH-1:0] tab_a   [DEPTH];
    logic [WIDTH-1:0] tab_b   [DEPTH];
    logic [WIDTH-1:0] tab_exp [DEPTH];

    seq_state_e    state;
    logic [IW-1:0] n;
    logic [IW-1:0] i;
    pipe_t         issue_ent;
    pipe_t         cmp_ent;
    logic          idle_like;
    logic          start_ok;
    logic          mismatch;
    logic          last_cmp;
    logic [IW-1:0] err_nxt;
    logic [IW-1:0] n_clip;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign start_ok  = idle_like && start && !load_en;
    assign mismatch  = cmp_ent.valid && (x != cmp_ent.exp);
    assign last_cmp  = cmp_ent.valid && (cmp_ent.idx == n - IW'(1));
    assign err_nxt   = err_count + IW'(mismatch);
    assign n_clip    = (num_vec > IW'(DEPTH)) ? IW'(DEPTH) : num_vec;

    // Table storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_en && idle_like) begin
            tab_a[load_addr]   <= load_a;
            tab_b[load_addr]   <= load_b;
            tab_exp[load_addr] <= load_exp;
        end
    end

    // Entry leaves the issue register in step with a/b, then waits out the DUT latency.
    vector_seq_delay #(
        .W       ($bits(pipe_t)),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (issue_ent),
        .q   (cmp_ent)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            n         <= '0;
            i         <= '0;
            a         <= '0;
            b         <= '0;
            issue_ent <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            first_err <= IW'(DEPTH);
            cyc       <= '0;
        end else begin
            a         <= '0;
            b         <= '0;
            issue_ent <= '0;
            busy      <= (state == S_RUN && n != '0) || (state == S_DRAIN && !last_cmp);
            if (busy) cyc <= cyc + 32'd1;
            if (mismatch) begin
                err_count <= err_nxt;
                if (err_count == '0) first_err <= cmp_ent.idx;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        n         <= n_clip;
                        i         <= '0;
                        err_count <= '0;
                        first_err <= IW'(DEPTH);
                        cyc       <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (n == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        a         <= tab_a[i[AW-1:0]];
                        b         <= tab_b[i[AW-1:0]];
                        issue_ent <= '{valid: 1'b1, idx: i, exp: tab_exp[i[AW-1:0]]};
                        i         <= i + IW'(1);
                        if (i == n - IW'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_cmp) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
